// File: rtl/schematic_alu_seq.sv
// Registered 14-operator ALU behind a 2-stage valid/ready pipeline, with a built-in sweep
// sequencer that folds every operator's result into a checksum. Optional macro: SCHEMATIC_ALU_PARITY_EN.
module schematic_alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_VEC = 4
) (
`ifdef SCHEMATIC_ALU_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       flags,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [WIDTH-1:0] checksum
);
  localparam int unsigned SEL_W = $clog2(WIDTH);
  localparam logic [3:0]  OP_LAST = 4'd13;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic             s1_valid, s2_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a, s1_b, s1_c;
  logic [WIDTH-1:0] s2_out;
  logic [2:0]       s2_flags;
  logic [WIDTH-1:0] sw_v;
  logic [3:0]       sw_op;
  logic [WIDTH-1:0] cs;

  logic             busy, out_ready_eff, s1_ready, s2_ready;
  logic             start_ok, last_inject, inject;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b, in_c;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic             res_carry, res_err;

  assign busy          = (state == RUN) || (state == DRAIN);
  assign out_ready_eff = busy || out_ready;
  assign s2_ready      = !s2_valid || out_ready_eff;
  assign s1_ready      = !s1_valid || s2_ready;
  assign in_ready      = s1_ready && (state == IDLE);
  assign start_ok      = (state == IDLE) && sweep_start && !s1_valid && !s2_valid;
  assign last_inject   = (state == RUN) && s1_ready && (sw_op == OP_LAST)
                         && (sw_v == WIDTH'(N_VEC - 1));

  assign out_valid  = s2_valid && !busy;
  assign out        = s2_out;
  assign flags      = s2_flags;
  assign sweep_busy = busy;
  assign sweep_done = (state == DONE);
  assign checksum   = cs;

  // Stage-1 source: the sequencer owns the pipeline while running.
  always_comb begin
    inject = in_valid && in_ready;
    in_op  = op;
    in_a   = a;
    in_b   = b;
    in_c   = c;
    if (state == RUN) begin
      inject = s1_ready;
      in_op  = sw_op;
      in_a   = sw_v;
      in_b   = ~sw_v;
      in_c   = sw_v + WIDTH'(1);
    end
  end

  assign sum = {1'b0, s1_a} + {1'b0, s1_b};

  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    res_err   = 1'b0;
    case (s1_op)
      4'd0:  res = s1_a;
      4'd1:  res = ~s1_a;
      4'd2:  res = WIDTH'(0) - s1_a;
      4'd3:  res = s1_a * s1_b;
      4'd4:  begin
        res       = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
      end
      4'd5:  res = s1_a & s1_b;
      4'd6:  res = WIDTH'(s1_a < s1_b);
      4'd7:  res = s1_a ^ s1_b;
      4'd8:  res = WIDTH'((|s1_a) && (|s1_b));
      4'd9:  res = WIDTH'((|s1_a) || (|s1_b));
      4'd10: res = (|s1_a) ? s1_b : s1_c;
      4'd11: res = s1_a | s1_b;
      4'd12: res = WIDTH'(s1_a[s1_b[SEL_W-1:0]]);
      4'd13: res = '1;
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (last_inject) state_nxt = DRAIN;
      DRAIN:   if (!s1_valid && !s2_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer operand generator and checksum fold.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sw_v  <= '0;
      sw_op <= '0;
      cs    <= '0;
    end else if (start_ok) begin
      sw_v  <= '0;
      sw_op <= '0;
      cs    <= '0;
    end else begin
      if ((state == RUN) && s1_ready) begin
        if (sw_op == OP_LAST) begin
          sw_op <= '0;
          sw_v  <= sw_v + WIDTH'(1);
        end else begin
          sw_op <= sw_op + 4'd1;
        end
      end
      if (busy && s2_valid) cs <= {cs[WIDTH-2:0], cs[WIDTH-1]} ^ s2_out;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_c       <= '0;
      s2_valid   <= 1'b0;
      s2_out     <= '0;
      s2_flags   <= '0;
`ifdef SCHEMATIC_ALU_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      if (s1_ready) begin
        s1_valid <= inject;
        if (inject) begin
          s1_op <= in_op;
          s1_a  <= in_a;
          s1_b  <= in_b;
          s1_c  <= in_c;
        end
      end
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_out     <= res;
          s2_flags   <= {res_err, res_carry, (res == '0)};
`ifdef SCHEMATIC_ALU_PARITY_EN
          out_parity <= ^res;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_schematic_alu_seq.sv
// Scoreboard bench for schematic_alu_seq: directed cases, randomized traffic with
// random backpressure, sweep self-test and mid-sweep reset.
module tb_schematic_alu_seq;
  localparam int W    = 8;
  localparam int NV   = 1;
  localparam int MOD  = 256;
  localparam int MASK = 255;

  typedef struct packed {
    logic [W-1:0] out;
    logic [2:0]   flags;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, c, out, checksum;
  logic [2:0]   flags;
  logic         sweep_start, sweep_busy, sweep_done;
`ifdef SCHEMATIC_ALU_PARITY_EN
  logic         out_parity;
`endif

  int   checks = 0;
  int   errors = 0;
  bit   bp_rand = 1'b0;
  exp_t q[$];

  schematic_alu_seq #(.WIDTH(W), .N_VEC(NV)) dut (
`ifdef SCHEMATIC_ALU_PARITY_EN
    .out_parity(out_parity),
`endif
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .flags(flags), .sweep_start(sweep_start), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int o, input int x, input int y, input int z);
    int r;
    bit err, carry;
    exp_t e;
    err = 1'b0;
    carry = 1'b0;
    case (o)
      0:  r = x;
      1:  r = MASK - x;
      2:  r = (MOD - x) % MOD;
      3:  r = (x * y) % MOD;
      4:  begin r = (x + y) % MOD; carry = ((x + y) >= MOD); end
      5:  r = x & y;
      6:  r = (x < y) ? 1 : 0;
      7:  r = x ^ y;
      8:  r = (x != 0 && y != 0) ? 1 : 0;
      9:  r = (x != 0 || y != 0) ? 1 : 0;
      10: r = (x != 0) ? y : z;
      11: r = x | y;
      12: r = (x >> (y % W)) & 1;
      13: r = MASK;
      default: begin r = 0; err = 1'b1; end
    endcase
    e.out   = W'(r);
    e.flags = {err, carry, (r == 0)};
    return e;
  endfunction

  function automatic logic [W-1:0] model_cs();
    int   cs;
    exp_t e;
    cs = 0;
    for (int v = 0; v < NV; v++)
      for (int o = 0; o < 14; o++) begin
        e  = model(o, v % MOD, MASK - (v % MOD), (v + 1) % MOD);
        cs = (((cs << 1) | (cs >> (W - 1))) & MASK) ^ int'(e.out);
      end
    return W'(cs);
  endfunction

  function automatic logic [W-1:0] rnd();
    return ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one operation; expected result enters the scoreboard at acceptance.
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W-1:0] z);
    int n;
    n = 0;
    op = o; a = x; b = y; c = z; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else q.push_back(model(int'(o), int'(x), int'(y), int'(z)));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [W-1:0] held;
    logic         hold_pend;
    exp_t         e;
    hold_pend = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (hold_pend && out_valid) check("hold_out", 32'(out), 32'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=%0h expected=none at %0t", out, $time);
        end else begin
          e = q.pop_front();
          check("out", 32'(out), 32'(e.out));
          check("flags", 32'(flags), 32'(e.flags));
`ifdef SCHEMATIC_ALU_PARITY_EN
          check("parity", 32'(out_parity), 32'(^e.out));
`endif
        end
      end
      hold_pend = out_valid && !out_ready;
      held = out;
    end
  endtask

  task automatic rand_ready();
    forever begin
      @(posedge clk);
      #1;
      if (bp_rand) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int n, done_cnt, busy_cnt;
    logic [W-1:0] cs_exp;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b0;
    op = '0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy", 32'(sweep_busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    fork
      monitor();
      rand_ready();
    join_none
    @(posedge clk);
    #1;

    // ADD with carry and two-cycle latency.
    send(4'd4, 8'hF0, 8'h20, 8'h00);
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    check("add_out", 32'(out), 32'h10);
    check("add_flags", 32'(flags), 32'b010);
    @(posedge clk);
    #1;
    send(4'd3, 8'h13, 8'h11, 8'h00);
    send(4'd2, 8'h01, 8'h00, 8'h00);
    send(4'd5, 8'h0F, 8'hF0, 8'h00);
    send(4'd14, 8'h55, 8'h00, 8'h00);
    send(4'd15, 8'hAA, 8'h01, 8'h00);
    wait_empty();

    // Backpressure: two accepts fill the pipe, output holds.
    out_ready = 1'b0;
    send(4'd0, 8'h01, 8'h00, 8'h00);
    send(4'd0, 8'h02, 8'h00, 8'h00);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out", 32'(out), 32'h01);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(4'd0, 8'h03, 8'h00, 8'h00);
    wait_empty();

    // Random traffic with random backpressure.
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(4'($urandom_range(0, 15)), rnd(), rnd(), rnd());
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_empty();
    bp_rand = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Sweep: user operands and a second start are ignored while busy.
    cs_exp = model_cs();
    sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    op = 4'd4; a = 8'h01; b = 8'h01; c = 8'h00; in_valid = 1'b1;
    done_cnt = 0; busy_cnt = 0; n = 0;
    while (done_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
      if (sweep_busy) begin
        busy_cnt++;
        check("sweep_out_valid", 32'(out_valid), 32'd0);
        check("sweep_in_ready", 32'(in_ready), 32'd0);
      end
      if (sweep_done) begin
        done_cnt++;
        in_valid = 1'b0;
      end
      sweep_start = (n == 5);
    end
    sweep_start = 1'b0;
    in_valid = 1'b0;
    check("sweep_done_seen", 32'(done_cnt), 32'd1);
    check("sweep_busy_len", 32'(busy_cnt), 32'd17);
    check("sweep_cs_model", 32'(checksum), 32'(cs_exp));
    check("sweep_cs_value", 32'(checksum), 32'h67);
    @(negedge clk);
    check("done_pulse", 32'(sweep_done), 32'd0);
    check("post_busy", 32'(sweep_busy), 32'd0);
    repeat (4) @(negedge clk);
    check("cs_hold", 32'(checksum), 32'(cs_exp));
    @(posedge clk);
    #1;

    // Reset in the middle of a sweep.
    sweep_start = 1'b1;
    @(posedge clk);
    #1 sweep_start = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", 32'(sweep_busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_checksum", 32'(checksum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_done", 32'(sweep_done), 32'd0);
    @(posedge clk);
    #1;
    send(4'd4, 8'hFF, 8'h01, 8'h00);
    send(4'd10, 8'h00, 8'h12, 8'h34);
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
